datamover_rd_ctrl: RTL
======================

DATAMOVER_RD_CTRL -- requirements
Module: datamover_rd_ctrl

Interface
REQ-001 SHALL have parameter CHUNK_BYTES, default 256: max BTT per MM2S command; legal values are multiples of 8 in the range 8..504.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: max issued commands whose tlast has not yet been seen; legal range 1..15.
REQ-003 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
REQ-004 SHALL have the request ports:
- i_req_valid  in  1  transfer request valid
- o_req_ready  out  1  request accepted while high with i_req_valid
- i_req_addr  in  32  transfer start byte address
- i_req_bytes  in  24  total transfer bytes
REQ-005 SHALL have the status ports:
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle transfer-complete pulse
- o_err_unexp  out  1  one-cycle pulse on unexpected tlast
REQ-006 SHALL have the command ports:
- i_mm2s_rd_cmd_tready  in  1  command ready
- o_mm2s_rd_cmd_tvalid  out  1  command valid
- o_mm2s_rd_cmd_tdata  out  72  command word
REQ-007 SHALL have the upstream stream ports:
- i_mm2s_rd_tdata  in  64  read data
- i_mm2s_rd_tkeep  in  8  byte enables
- i_mm2s_rd_tvalid  in  1  data valid
- i_mm2s_rd_tlast  in  1  last beat of a command
- o_mm2s_rd_tready  out  1  ready to upstream
REQ-008 SHALL have the downstream stream ports:
- o_m_tdata  out  64  forwarded data
- o_m_tkeep  out  8  forwarded byte enables
- o_m_tvalid  out  1  forwarded valid
- o_m_tlast  out  1  last beat of the whole transfer
- i_m_tready  in  1  downstream ready

Function
REQ-009 SHALL implement FSM states IDLE, CMD, DRAIN.
- IDLE: o_req_ready=1.
- Request handshake with i_req_bytes!=0 -> CMD.
- Request handshake with i_req_bytes==0 -> stay IDLE; pulse o_done on the next cycle; issue no command.
REQ-010 SHALL latch on the request handshake: next address = i_req_addr, remaining = i_req_bytes, sequence tag = 0.
REQ-011 SHALL compute chunk BTT = min(remaining, CHUNK_BYTES), 9 bits wide.
REQ-012 SHALL assemble the command word as:
- [71:64] tag
- [63:32] address
- [31] 0
- [30] 1 (EOF)
- [29:23] 7'd1
- [22:9] 0
- [8:0] BTT
REQ-013 SHALL drive o_mm2s_rd_cmd_tvalid from a register.
- In CMD, tvalid asserts only when outstanding < MAX_OUTSTANDING.
- Once asserted, tvalid and tdata SHALL hold stable until i_mm2s_rd_cmd_tready.
REQ-014 SHALL, on each command handshake:
- address += BTT
- remaining -= BTT
- tag += 1 (8-bit wrap)
- outstanding += 1
- if the new remaining == 0 -> DRAIN, tvalid deasserts the following cycle
- otherwise the next command may assert the cycle immediately after
REQ-015 SHALL decrement outstanding on each upstream beat with i_mm2s_rd_tvalid & o_mm2s_rd_tready & i_mm2s_rd_tlast.
- A command handshake and a tlast beat in the same cycle leave outstanding unchanged.
REQ-016 SHALL make the stream pass-through combinational:
- o_mm2s_rd_tready = i_m_tready
- o_m_tdata, o_m_tkeep, o_m_tvalid mirror the upstream signals
REQ-017 SHALL assert o_m_tlast = i_mm2s_rd_tlast only when in DRAIN with outstanding==1; otherwise o_m_tlast=0.
REQ-018 SHALL leave DRAIN for IDLE on the cycle after outstanding reaches 0, pulsing o_done for exactly one cycle.
REQ-019 SHALL, on a tlast beat while outstanding==0:
- hold outstanding at 0 (no underflow)
- pulse o_err_unexp one cycle later
- leave the FSM unaffected
REQ-020 SHALL hold o_busy=1 in CMD and DRAIN, and 0 in IDLE.
REQ-021 SHALL ignore i_req_valid outside IDLE (o_req_ready=0).
REQ-022 SHALL let address arithmetic wrap modulo 2^32 without error.

Reset
REQ-023 SHALL, while rst=1 on a clock edge, force:
- FSM to IDLE
- outstanding, remaining, tag = 0
- o_mm2s_rd_cmd_tvalid=0, o_mm2s_rd_cmd_tdata=0
- o_done=0, o_err_unexp=0, o_busy=0
REQ-024 SHALL, when reset is applied mid-transfer, abandon all pending and in-flight commands with no o_done pulse; first request accepted on the first cycle after rst deasserts.

Verification
REQ-025 SHALL cover: addr=0x1000_0000, bytes=600, cmd_tready=1, upstream tlast returned per command -> 3 commands:
- BTT 256 at 0x1000_0000, tag 0
- BTT 256 at 0x1000_0100, tag 1
- BTT 88 at 0x1000_0200, tag 2
- o_m_tlast only on the third tlast; o_done one cycle after it
REQ-026 SHALL cover: bytes=2048 with no tlast returned -> exactly 4 commands, then tvalid stays 0; after one tlast, the 5th command issues.
REQ-027 SHALL cover: cmd_tready held 0 for 10 cycles -> tvalid=1 and tdata stable (0x00_10000000_40800100 form with the correct fields) throughout.
REQ-028 SHALL cover: bytes=0 -> no command; o_done one cycle after the handshake; o_busy never asserted.
REQ-029 SHALL cover: command handshake and tlast in the same cycle -> outstanding unchanged; unsolicited tlast in IDLE -> o_err_unexp pulse, outstanding stays 0.
REQ-030 SHALL cover: rst asserted with 2 commands outstanding -> all outputs at reset values next cycle; no o_done; a new request is accepted immediately after rst deasserts.

Source files
------------

// File: rtl/datamover_rd_ctrl_if.sv
// Bundle of request, status, MM2S command and stream signals
// for the datamover read controller.
interface datamover_rd_ctrl_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [23:0] i_req_bytes;

    logic        o_busy;
    logic        o_done;
    logic        o_err_unexp;

    logic        i_mm2s_rd_cmd_tready;
    logic        o_mm2s_rd_cmd_tvalid;
    logic [71:0] o_mm2s_rd_cmd_tdata;

    logic [63:0] i_mm2s_rd_tdata;
    logic [7:0]  i_mm2s_rd_tkeep;
    logic        i_mm2s_rd_tvalid;
    logic        i_mm2s_rd_tlast;
    logic        o_mm2s_rd_tready;

    logic [63:0] o_m_tdata;
    logic [7:0]  o_m_tkeep;
    logic        o_m_tvalid;
    logic        o_m_tlast;
    logic        i_m_tready;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_bytes,
        input  i_mm2s_rd_cmd_tready,
        input  i_mm2s_rd_tdata, i_mm2s_rd_tkeep,
        input  i_mm2s_rd_tvalid, i_mm2s_rd_tlast,
        input  i_m_tready,
        output o_req_ready, o_busy, o_done, o_err_unexp,
        output o_mm2s_rd_cmd_tvalid, o_mm2s_rd_cmd_tdata,
        output o_mm2s_rd_tready,
        output o_m_tdata, o_m_tkeep, o_m_tvalid, o_m_tlast
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_bytes,
        output i_mm2s_rd_cmd_tready,
        output i_mm2s_rd_tdata, i_mm2s_rd_tkeep,
        output i_mm2s_rd_tvalid, i_mm2s_rd_tlast,
        output i_m_tready,
        input  o_req_ready, o_busy, o_done, o_err_unexp,
        input  o_mm2s_rd_cmd_tvalid, o_mm2s_rd_cmd_tdata,
        input  o_mm2s_rd_tready,
        input  o_m_tdata, o_m_tkeep, o_m_tvalid, o_m_tlast
    );
endinterface

// File: rtl/datamover_rd_ctrl.sv
// Splits a transfer request into MM2S read commands of at most
// CHUNK_BYTES and forwards the returned stream downstream.
module datamover_rd_ctrl #(
    parameter int CHUNK_BYTES     = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    datamover_rd_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMD, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] addr, addr_n;
    logic [23:0] remaining, rem_n;
    logic [7:0]  tag, tag_n;
    logic [3:0]  outstanding, out_n;
    logic        cmd_tvalid, tvalid_n;
    logic [71:0] cmd_tdata, tdata_n;
    logic        done, done_n, err_unexp;
    logic        cmd_hs, tlast_beat, last_ret, can_issue;
    logic [8:0]  btt, btt_n;

    function automatic logic [8:0] chunk(input logic [23:0] r);
        return (r < 24'(CHUNK_BYTES)) ? r[8:0] : 9'(CHUNK_BYTES);
    endfunction

    assign cmd_hs     = cmd_tvalid & bus.i_mm2s_rd_cmd_tready;
    assign tlast_beat = bus.i_mm2s_rd_tvalid & bus.i_m_tready
                      & bus.i_mm2s_rd_tlast;
    assign last_ret   = tlast_beat && (outstanding != 4'd0);
    assign btt        = chunk(remaining);

    // A tlast with nothing outstanding is flagged, not counted.
    always_comb begin
        out_n = outstanding;
        if (cmd_hs && !last_ret)
            out_n = outstanding + 4'd1;
        else if (!cmd_hs && last_ret)
            out_n = outstanding - 4'd1;
    end

    assign can_issue = out_n < 4'(MAX_OUTSTANDING);

    always_comb begin
        state_n  = state;
        addr_n   = addr;
        rem_n    = remaining;
        tag_n    = tag;
        tvalid_n = cmd_tvalid;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_req_valid) begin
                    if (bus.i_req_bytes != 24'd0) begin
                        state_n  = CMD;
                        addr_n   = bus.i_req_addr;
                        rem_n    = bus.i_req_bytes;
                        tag_n    = 8'd0;
                        tvalid_n = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            CMD: begin
                if (cmd_hs) begin
                    addr_n = addr + {23'd0, btt};
                    rem_n  = remaining - {15'd0, btt};
                    tag_n  = tag + 8'd1;
                    if (rem_n == 24'd0) begin
                        state_n  = DRAIN;
                        tvalid_n = 1'b0;
                    end else begin
                        tvalid_n = can_issue;
                    end
                end else if (!cmd_tvalid) begin
                    tvalid_n = can_issue;
                end
            end
            DRAIN: begin
                if (out_n == 4'd0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        btt_n   = chunk(rem_n);
        tdata_n = {tag_n, addr_n, 1'b0, 1'b1, 7'd1, 14'd0, btt_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= 32'd0;
            remaining   <= 24'd0;
            tag         <= 8'd0;
            outstanding <= 4'd0;
            cmd_tvalid  <= 1'b0;
            cmd_tdata   <= 72'd0;
            done        <= 1'b0;
            err_unexp   <= 1'b0;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            remaining   <= rem_n;
            tag         <= tag_n;
            outstanding <= out_n;
            cmd_tvalid  <= tvalid_n;
            // Load only for a fresh command so a stalled one stays stable.
            if (tvalid_n && (!cmd_tvalid || cmd_hs))
                cmd_tdata <= tdata_n;
            done        <= done_n;
            err_unexp   <= tlast_beat && (outstanding == 4'd0);
        end
    end

    assign bus.o_req_ready          = (state == IDLE);
    assign bus.o_busy               = (state != IDLE);
    assign bus.o_done               = done;
    assign bus.o_err_unexp          = err_unexp;
    assign bus.o_mm2s_rd_cmd_tvalid = cmd_tvalid;
    assign bus.o_mm2s_rd_cmd_tdata  = cmd_tdata;
    assign bus.o_mm2s_rd_tready     = bus.i_m_tready;
    assign bus.o_m_tdata            = bus.i_mm2s_rd_tdata;
    assign bus.o_m_tkeep            = bus.i_mm2s_rd_tkeep;
    assign bus.o_m_tvalid           = bus.i_mm2s_rd_tvalid;
    assign bus.o_m_tlast            = bus.i_mm2s_rd_tlast
                                    & (state == DRAIN)
                                    & (outstanding == 4'd1);
endmodule
